// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared data width, ALU opcodes and operand-B select encodings
package cpu_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_INC   = 4'd9;
  localparam logic [3:0] OP_DEC   = 4'd10;
  localparam logic [3:0] OP_ADC   = 4'd11;
  localparam logic [3:0] OP_SBB   = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;
  localparam logic [3:0] OP_ROL   = 4'd14;
  localparam logic [3:0] OP_PASSA = 4'd15;

  localparam logic [1:0] SEL_IMM = 2'd0;
  localparam logic [1:0] SEL_REG = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_ACC = 2'd3;

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational ALU: result, carry/borrow out and zero detect
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic [3:0]   op,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         z
);

  logic [W:0] ext;

  // Arithmetic runs one bit wider so bit W is the carry, or the borrow for subtracts.
  always_comb begin
    ext    = '0;
    result = b;
    c_out  = 1'b0;
    case (op)
      OP_PASSB: result = b;
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[W-1:0];
        c_out  = ext[W];
      end
      OP_SUB, OP_CMP: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[W-1:0];
        c_out  = ext[W];
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL: begin
        result = {a[W-2:0], 1'b0};
        c_out  = a[W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[W-1:1]};
        c_out  = a[0];
      end
      OP_INC: begin
        ext    = {1'b0, a} + {{W{1'b0}}, 1'b1};
        result = ext[W-1:0];
        c_out  = ext[W];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - {{W{1'b0}}, 1'b1};
        result = ext[W-1:0];
        c_out  = ext[W];
      end
      OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        result = ext[W-1:0];
        c_out  = ext[W];
      end
      OP_SBB: begin
        ext    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c_in};
        result = ext[W-1:0];
        c_out  = ext[W];
      end
      OP_ROL: begin
        result = {a[W-2:0], c_in};
        c_out  = a[W-1];
      end
      OP_PASSA: result = a;
      default:  result = b;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - accumulator datapath with register file, data memory and optional flags (CPU_FLAGS_EN)
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH          = 13,
  parameter int IWIDTH         = 5,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [IWIDTH-2:0]         ALU_OUT,
  input  logic [WIDTH-IWIDTH-1:0]   IMM,
  input  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
  input  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
  input  logic                      EN_REG_F,
  input  logic [WIDTH-IWIDTH-1:0]   D_MEM_ADDR,
  input  logic                      D_MEM_ADDR_MODE,
  input  logic                      EN_D_MEM,
  input  logic                      EN_ACC,
  output logic [WIDTH-IWIDTH-1:0]   ACC_OUT,
  output logic                      FLAG_Z,
  output logic                      FLAG_C
);

  localparam int DATA_W = WIDTH - IWIDTH;
  localparam int NREG   = 2 ** REG_F_SEL_SIZE;
  localparam int NMEM   = 2 ** DATA_W;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] regf_q [NREG];
  logic [DATA_W-1:0] regf_d [NREG];
  logic [DATA_W-1:0] d_mem  [NMEM];

  logic [DATA_W-1:0] ea;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_z;
  logic              carry_in;

  // Effective address and operand B come from pre-edge state only (no write bypass).
  always_comb begin
    ea = D_MEM_ADDR_MODE ? regf_q[REG_F_SEL] : D_MEM_ADDR;
    case (IN_B_SEL)
      SEL_IMM: op_b = IMM;
      SEL_REG: op_b = regf_q[REG_F_SEL];
      SEL_MEM: op_b = d_mem[ea];
      SEL_ACC: op_b = acc_q;
      default: op_b = IMM;
    endcase
  end

  cpu_alu #(.W(DATA_W)) u_alu (
    .a      (acc_q),
    .b      (op_b),
    .c_in   (carry_in),
    .op     (ALU_OUT),
    .result (alu_result),
    .c_out  (alu_c),
    .z      (alu_z)
  );

  // Next accumulator and register-file contents; stores always take the old accumulator.
  always_comb begin
    acc_d  = acc_q;
    regf_d = regf_q;
    if (EN_ACC && (ALU_OUT != OP_CMP)) acc_d = alu_result;
    if (EN_REG_F) regf_d[REG_F_SEL] = acc_q;
  end

  // Accumulator and register file, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
      for (int i = 0; i < NREG; i++) regf_q[i] <= '0;
    end else begin
      acc_q  <= acc_d;
      regf_q <= regf_d;
    end
  end

  // Data memory has no reset; contents are only meaningful once written.
  always_ff @(posedge CLK) begin
    if (EN_D_MEM) d_mem[ea] <= acc_q;
  end

  assign ACC_OUT = acc_q;

`ifdef CPU_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;

  // Flags follow the ALU only on cycles that commit to the accumulator (CMP included).
  always_comb begin
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (EN_ACC) begin
      flag_z_d = alu_z;
      flag_c_d = alu_c;
    end
  end

  // Flag registers; reset state reflects the cleared accumulator.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      flag_z_q <= 1'b1;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign carry_in = flag_c_q;
  assign FLAG_Z   = flag_z_q;
  assign FLAG_C   = flag_c_q;
`else
  // A zero carry-in turns ADC/SBB/ROL into ADD/SUB/SHL.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_z ^ alu_c;
  assign carry_in = 1'b0;
  assign FLAG_Z   = 1'b0;
  assign FLAG_C   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - self-checking bench for cpu_datapath against a behavioural model
module tb_cpu_datapath;
  import cpu_pkg::*;

`ifdef CPU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic [3:0] ALU_OUT;
  logic [7:0] IMM;
  logic [1:0] IN_B_SEL;
  logic [3:0] REG_F_SEL;
  logic       EN_REG_F;
  logic [7:0] D_MEM_ADDR;
  logic       D_MEM_ADDR_MODE;
  logic       EN_D_MEM;
  logic       EN_ACC;
  logic [7:0] ACC_OUT;
  logic       FLAG_Z;
  logic       FLAG_C;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_acc;
  logic       m_z;
  logic       m_c;
  logic [7:0] m_regf [16];
  logic [7:0] m_mem  [256];

  cpu_datapath dut (
    .CLK             (CLK),
    .RST             (RST),
    .ALU_OUT         (ALU_OUT),
    .IMM             (IMM),
    .IN_B_SEL        (IN_B_SEL),
    .REG_F_SEL       (REG_F_SEL),
    .EN_REG_F        (EN_REG_F),
    .D_MEM_ADDR      (D_MEM_ADDR),
    .D_MEM_ADDR_MODE (D_MEM_ADDR_MODE),
    .EN_D_MEM        (EN_D_MEM),
    .EN_ACC          (EN_ACC),
    .ACC_OUT         (ACC_OUT),
    .FLAG_Z          (FLAG_Z),
    .FLAG_C          (FLAG_C)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_acc = 8'h00;
    m_z   = FLAGS;
    m_c   = 1'b0;
    for (int i = 0; i < 16; i++) m_regf[i] = 8'h00;
  endtask

  // Drive one control word, advance the model by the instruction rules, then step one edge.
  task automatic apply(input logic [3:0] op, input logic [7:0] imm, input logic [1:0] bsel,
                       input logic [3:0] rsel, input logic en_reg, input logic [7:0] addr,
                       input logic mode, input logic en_mem, input logic en_acc);
    int a, b, r, c, cin;
    logic [7:0] ea;
    ALU_OUT = op; IMM = imm; IN_B_SEL = bsel; REG_F_SEL = rsel; EN_REG_F = en_reg;
    D_MEM_ADDR = addr; D_MEM_ADDR_MODE = mode; EN_D_MEM = en_mem; EN_ACC = en_acc;
    a   = int'(m_acc);
    ea  = mode ? m_regf[rsel] : addr;
    cin = FLAGS ? int'(m_c) : 0;
    case (bsel)
      2'd0:    b = int'(imm);
      2'd1:    b = int'(m_regf[rsel]);
      2'd2:    b = int'(m_mem[ea]);
      default: b = a;
    endcase
    c = 0;
    case (int'(op))
      0:  r = b;
      1:  begin r = a + b; c = (r > 255); end
      2:  begin r = a - b; c = (a < b); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = ~a;
      7:  begin r = a << 1; c = a >> 7; end
      8:  begin r = a >> 1; c = a & 1; end
      9:  begin r = a + 1; c = (r > 255); end
      10: begin r = a - 1; c = (a < 1); end
      11: begin r = a + b + cin; c = (r > 255); end
      12: begin r = a - b - cin; c = (a < b + cin); end
      13: begin r = a - b; c = (a < b); end
      14: begin r = (a << 1) | cin; c = a >> 7; end
      default: r = a;
    endcase
    r = r & 255;
    if (en_reg) m_regf[rsel] = m_acc;
    if (en_mem) m_mem[ea] = m_acc;
    if (en_acc) begin
      if (int'(op) != 13) m_acc = r[7:0];
      if (FLAGS) begin
        m_z = (r == 0);
        m_c = (c != 0);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (ACC_OUT !== 8'h00) begin bad++; $display("FAIL reset_acc got=%h exp=00", ACC_OUT); end
    total++; if (FLAG_Z !== FLAGS) begin bad++; $display("FAIL reset_z got=%b exp=%b", FLAG_Z, FLAGS); end
    total++; if (FLAG_C !== 1'b0) begin bad++; $display("FAIL reset_c got=%b exp=0", FLAG_C); end
    #10 RST = 1'b1;
    apply(OP_PASSB, 8'h5A, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_PASSB, 8'h00, SEL_IMM, 4'd3, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    total++; if (ACC_OUT !== 8'h5A) begin bad++; $display("FAIL pre_reset_acc got=%h exp=5a", ACC_OUT); end
    #3 RST = 1'b0;
    model_reset();
    #1;
    total++; if (ACC_OUT !== 8'h00) begin bad++; $display("FAIL midrun_reset_acc got=%h exp=00", ACC_OUT); end
    total++; if (FLAG_Z !== FLAGS) begin bad++; $display("FAIL midrun_reset_z got=%b exp=%b", FLAG_Z, FLAGS); end
    total++; if (FLAG_C !== 1'b0) begin bad++; $display("FAIL midrun_reset_c got=%b exp=0", FLAG_C); end
    #2 RST = 1'b1;
    apply(OP_PASSB, 8'h00, SEL_REG, 4'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h00) begin bad++; $display("FAIL reset_regf3 got=%h exp=00", ACC_OUT); end
  endtask

  task automatic test_add_adc();
    apply(OP_PASSB, 8'hF0, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_ADD, 8'h20, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h10) begin bad++; $display("FAIL add_acc got=%h exp=10", ACC_OUT); end
    total++; if (FLAG_C !== FLAGS) begin bad++; $display("FAIL add_c got=%b exp=%b", FLAG_C, FLAGS); end
    total++; if (FLAG_Z !== 1'b0) begin bad++; $display("FAIL add_z got=%b exp=0", FLAG_Z); end
    apply(OP_ADC, 8'h00, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== (FLAGS ? 8'h11 : 8'h10)) begin bad++; $display("FAIL adc_acc got=%h exp=%h", ACC_OUT, FLAGS ? 8'h11 : 8'h10); end
    total++; if (FLAG_C !== 1'b0) begin bad++; $display("FAIL adc_c got=%b exp=0", FLAG_C); end
  endtask

  task automatic test_sub_cmp();
    apply(OP_PASSB, 8'h05, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_SUB, 8'h05, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h00) begin bad++; $display("FAIL sub_acc got=%h exp=00", ACC_OUT); end
    total++; if (FLAG_Z !== FLAGS) begin bad++; $display("FAIL sub_z got=%b exp=%b", FLAG_Z, FLAGS); end
    total++; if (FLAG_C !== 1'b0) begin bad++; $display("FAIL sub_c got=%b exp=0", FLAG_C); end
    apply(OP_CMP, 8'h06, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h00) begin bad++; $display("FAIL cmp_acc got=%h exp=00", ACC_OUT); end
    total++; if (FLAG_C !== FLAGS) begin bad++; $display("FAIL cmp_c got=%b exp=%b", FLAG_C, FLAGS); end
    total++; if (FLAG_Z !== 1'b0) begin bad++; $display("FAIL cmp_z got=%b exp=0", FLAG_Z); end
  endtask

  task automatic test_regf_store();
    apply(OP_PASSB, 8'h3C, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_PASSB, 8'h07, SEL_IMM, 4'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h07) begin bad++; $display("FAIL regf_same_cycle_acc got=%h exp=07", ACC_OUT); end
    apply(OP_PASSB, 8'h00, SEL_REG, 4'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h3C) begin bad++; $display("FAIL regf2_old_acc got=%h exp=3c", ACC_OUT); end
  endtask

  task automatic test_indirect_mem();
    apply(OP_PASSB, 8'h80, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_PASSB, 8'hAB, SEL_IMM, 4'd4, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_PASSB, 8'h00, SEL_IMM, 4'd4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(OP_PASSB, 8'h00, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_PASSB, 8'h00, SEL_MEM, 4'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'hAB) begin bad++; $display("FAIL indirect_store got=%h exp=ab", ACC_OUT); end
    // REG_F[4]=0x80 still; update it and store indirectly on the same edge: address uses old 0x80
    apply(OP_PASSB, 8'h11, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_PASSB, 8'h00, SEL_IMM, 4'd4, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(OP_PASSB, 8'h00, SEL_MEM, 4'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h11) begin bad++; $display("FAIL indirect_old_ea got=%h exp=11", ACC_OUT); end
    apply(OP_PASSB, 8'h00, SEL_REG, 4'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h11) begin bad++; $display("FAIL regf4_update got=%h exp=11", ACC_OUT); end
  endtask

  task automatic test_add_wrap();
    apply(OP_PASSB, 8'hFF, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    apply(OP_ADD, 8'h02, SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    total++; if (ACC_OUT !== 8'h01) begin bad++; $display("FAIL add_wrap_acc got=%h exp=01", ACC_OUT); end
    total++; if (FLAG_C !== FLAGS) begin bad++; $display("FAIL add_wrap_c got=%b exp=%b", FLAG_C, FLAGS); end
    total++; if (FLAG_Z !== 1'b0) begin bad++; $display("FAIL add_wrap_z got=%b exp=0", FLAG_Z); end
  endtask

  task automatic preload_mem();
    for (int i = 0; i < 256; i++) begin
      apply(OP_PASSB, 8'($urandom_range(0, 255)), SEL_IMM, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      apply(OP_PASSB, 8'h00, SEL_IMM, 4'd0, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      total++; if (ACC_OUT !== m_acc) begin bad++; $display("FAIL rand_acc step=%0d got=%h exp=%h", n, ACC_OUT, m_acc); end
      total++; if (FLAG_Z !== m_z) begin bad++; $display("FAIL rand_z step=%0d got=%b exp=%b", n, FLAG_Z, m_z); end
      total++; if (FLAG_C !== m_c) begin bad++; $display("FAIL rand_c step=%0d got=%b exp=%b", n, FLAG_C, m_c); end
    end
  endtask

  initial begin
    RST = 1'b0;
    ALU_OUT = 4'd0; IMM = 8'h00; IN_B_SEL = 2'd0; REG_F_SEL = 4'd0; EN_REG_F = 1'b0;
    D_MEM_ADDR = 8'h00; D_MEM_ADDR_MODE = 1'b0; EN_D_MEM = 1'b0; EN_ACC = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    model_reset();
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_regf_store();
    test_indirect_mem();
    test_add_wrap();
    preload_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
